// File: rtl/mem_pkg.sv
// Shared definitions for the program/data RAM arbiter.
// Covers arbiter FSM states, default bus widths and master indices.
package mem_pkg;

    localparam int MEM_AW = 12;
    localparam int MEM_DW = 32;

    localparam logic M_CORE = 1'b0;
    localparam logic M_UART = 1'b1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One master's request/grant port into the RAM arbiter.
// Handshake: a master raises req with addr/we/wdata/lock stable and holds them until gnt=1;
// the access is taken at the edge that ends the gnt cycle; reads return rvalid one cycle later.
interface mem_arbiter_if #(
    parameter int AW = mem_pkg::MEM_AW,
    parameter int DW = mem_pkg::MEM_DW
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on contention ptr selects the winner.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       winner
);
    assign valid  = |req;
    assign winner = (&req) ? ptr : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port synchronous RAM between the CPU core (m0) and UART loader (m1).
// Round-robin arbitration with a bounded lock (burst); one access per cycle.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter  int AW        = MEM_AW,
    parameter  int DW        = MEM_DW,
    parameter  int MAX_BURST = 16,
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output arb_state_t    dbg_state,
    output logic          dbg_rr_ptr,
    output logic [CW-1:0] dbg_burst_cnt
);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam bit            LOCK_EN  = (MAX_BURST > 1);

    arb_state_t    state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0_raw, gnt1_raw;
    logic          pick_valid, pick_winner;

    rr_pick2 u_pick (
        .req    ({m1.req, m0.req}),
        .ptr    (rr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        case (state_q)
            ARB: begin
                if (pick_valid) begin
                    if (pick_winner == M_UART) begin
                        gnt1_raw = 1'b1;
                        rr_d     = M_CORE;
                        if (m1.lock && LOCK_EN) begin
                            state_d = LOCK1;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        gnt0_raw = 1'b1;
                        rr_d     = M_UART;
                        if (m0.lock && LOCK_EN) begin
                            state_d = LOCK0;
                            cnt_d   = CW'(1);
                        end
                    end
                end
            end
            // While locked the other master waits even if it is requesting.
            LOCK0: begin
                if (!m0.req) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    gnt0_raw = 1'b1;
                    if (!m0.lock) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ARB;
                        cnt_d   = '0;
                        rr_d    = M_UART;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOCK1: begin
                if (!m1.req) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    gnt1_raw = 1'b1;
                    if (!m1.lock) begin
                        state_d = ARB;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ARB;
                        cnt_d   = '0;
                        rr_d    = M_CORE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ARB;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            rr_q    <= M_CORE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grants are forced low while reset is held so no write can slip through.
    assign m0.gnt = gnt0_raw & rst_n;
    assign m1.gnt = gnt1_raw & rst_n;

    assign ram_addr  = m1.gnt ? m1.addr  : m0.addr;
    assign ram_wdata = m1.gnt ? m1.wdata : m0.wdata;
    assign ram_we    = (m0.gnt & m0.we) | (m1.gnt & m1.we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0.rvalid <= 1'b0;
            m1.rvalid <= 1'b0;
        end else begin
            m0.rvalid <= m0.gnt & ~m0.we;
            m1.rvalid <= m1.gnt & ~m1.we;
        end
    end

    assign m0.rdata = ram_q;
    assign m1.rdata = ram_q;

    assign dbg_state     = state_q;
    assign dbg_rr_ptr    = rr_q;
    assign dbg_burst_cnt = cnt_q;

endmodule
